// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and flag bundle for the multi-cycle ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_NOR  = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_MUL  = 4'b1011
  } alu_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// Latency: start captured at edge k, done_o pulses for the cycle after edge k+WIDTH.
// Backpressure: none; the caller only starts it when it can take the result.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;

  // One add-and-shift step per busy cycle; the last step raises done.
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH-1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Reset discards any partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q;

endmodule

// File: rtl/alu_mc.sv
// ALU with single-cycle ops and an optional iterative multiply, one registered output slot.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for multiply.
// Backpressure: in_ready drops while multiplying or while the held result is not being drained.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,  // power of two, >= 8
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] res_q;
  alu_flags_t       flags_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] sub_r;
  logic             is_mul;
  logic [WIDTH-1:0] res_c;
  alu_flags_t       flags_c;

  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic             load;
  logic [WIDTH-1:0] load_res;
  alu_flags_t       load_flags;

  // Upper bits of b are deliberately ignored for shifts.
  assign shamt  = b[SHW-1:0];
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_r  = a - b;
  assign is_mul = (MUL_EN != 0) && (alu_ctrl == OP_MUL);

  // Single-cycle datapath; mul and undefined codes fall through to zero here.
  always_comb begin
    res_c         = '0;
    flags_c.carry = 1'b0;
    flags_c.ovf   = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        res_c         = add_w[WIDTH-1:0];
        flags_c.carry = add_w[WIDTH];
        flags_c.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c         = sub_r;
        flags_c.carry = (a >= b);
        flags_c.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_NOR:  res_c = ~(a | b);
      OP_XOR:  res_c = a ^ b;
      OP_SLL:  res_c = a << shamt;
      OP_SRL:  res_c = a >> shamt;
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRA:  res_c = $signed(a) >>> shamt;
      default: res_c = '0;
    endcase
    flags_c.zero = (res_c == '0);
    flags_c.neg  = res_c[WIDTH-1];
  end

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Accept only from IDLE with the output slot free or draining this cycle.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);

  // Next state and output-slot load selection.
  always_comb begin
    state_d    = state_q;
    mul_start  = 1'b0;
    load       = 1'b0;
    load_res   = res_c;
    load_flags = flags_c;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = ST_MUL_BUSY;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          load             = 1'b1;
          load_res         = mul_prod;
          load_flags.zero  = (mul_prod == '0);
          load_flags.neg   = mul_prod[WIDTH-1];
          load_flags.carry = 1'b0;
          load_flags.ovf   = 1'b0;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output slot: a new result replaces a draining one; otherwise hold until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      res_q       <= load_res;
      flags_q     <= load_flags;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = res_q;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two and at least 8.
REQ-002 Parameter MUL_EN, default 1, enables the multi-cycle multiply op.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 alu_ctrl  input  4  operation select.
REQ-009 out_valid  output  1  result held valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 alu_out  output  WIDTH  result.
REQ-012 zero, neg, carry, ovf  output  1 each  flags registered with alu_out.

Function
REQ-013 Op codes SHALL be: 0000 add; 0001 sub; 0010 and; 0011 or; 0100 nor; 0101 xor; 0110 sll; 0111 srl; 1000 slt (signed); 1001 sltu; 1010 sra; 1011 mul (low WIDTH bits of a*b); all others give result 0 with flags computed on 0.
REQ-014 When MUL_EN=0, op 1011 SHALL behave as an undefined code: result 0, single-cycle.
REQ-015 Shift amount SHALL be b[log2(WIDTH)-1:0], and the upper bits of b SHALL be ignored.
REQ-016 slt/sltu result SHALL be zero-extended 1 or 0.
REQ-017 zero = (alu_out==0); neg = alu_out[WIDTH-1].
REQ-018 carry: add = carry-out; sub = 1 when a>=b unsigned (no borrow); 0 for other ops.
REQ-019 ovf SHALL be signed overflow for add/sub and 0 for other ops.
REQ-020 A transfer SHALL occur on a rising edge where in_valid && in_ready, and likewise where out_valid && out_ready.
REQ-021 The FSM SHALL have two states: IDLE and MUL_BUSY.
REQ-022 in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-023 A non-mul op accepted at edge k SHALL present alu_out/flags with out_valid=1 after edge k (latency 1).
REQ-024 A mul op accepted at edge k SHALL enter MUL_BUSY, perform one shift-add step per cycle for WIDTH cycles, then load the result and assert out_valid after edge k+WIDTH+1, and return to IDLE.
REQ-025 While in MUL_BUSY, in_ready SHALL be 0 and inputs SHALL be ignored.
REQ-026 alu_out and flags SHALL hold stable while out_valid && !out_ready.
REQ-027 On a simultaneous output drain and new acceptance in one cycle, the new result SHALL replace the old one with out_valid remaining 1 (full throughput of 1 op/cycle for non-mul ops).
REQ-028 out_valid SHALL drop after an edge with out_ready=1 when no new result is loaded.
REQ-029 A mul result that completes while the prior result is unconsumed is impossible by construction, because REQ-022 blocks acceptance unless the output slot is free or draining.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, out_valid=0, alu_out=0, and all flags=0, including mid-multiply; the partial product SHALL be discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Package alu_pkg SHALL hold the 4-bit op-code constants/enum, the FSM state enum, and the flag bundle struct {zero, neg, carry, ovf}.
REQ-033 Sub-module alu_mul_seq SHALL implement the iterative shift-add multiplier with start/done handshake and a WIDTH-cycle step counter.
REQ-034 The combinational single-cycle datapath SHALL remain in alu_mc.

Verification
REQ-035 Back-to-back add 0x7FFFFFFF+1 then sub 5-7 with out_ready=1 -> results 0x80000000 (ovf=1, neg=1), then 0xFFFFFFFE (carry=0, neg=1) on consecutive cycles.
REQ-036 mul 0x0000FFFF*0x00010001 -> alu_out 0xFFFFFFFF exactly 33 cycles after acceptance, in_ready=0 throughout MUL_BUSY.
REQ-037 slt 0xFFFFFFFF,1 -> 1; sltu 0xFFFFFFFF,1 -> 0; sra 0x80000000 by b=0x21 -> 0xC0000000 (shift of 1).
REQ-038 out_ready=0 for 4 cycles after a result -> alu_out stable, in_ready=0; release -> drains and next op is accepted in the same cycle.
REQ-039 rst_n asserted at cycle 10 of a multiply -> out_valid=0 immediately, in_ready=1 after release, next add correct.
REQ-040 WIDTH=8, MUL_EN=0 instance: op 1011 -> 0 with zero=1 in 1 cycle; undefined op 1111 -> 0.
